activity_led: RTL and testbench

Turns short, bursty event strobes into blinks a person can see on a board LED. It drives an output pin, which makes it the output-side counterpart of the push-button input conditioning. Each rising edge of `event` produces one blink: the LED is on for exactly `ON_CYCLES` cycles and then off for at least `OFF_CYCLES` cycles. Edges that arrive during a blink are queued in a saturating counter. Typical users are the Ethernet MAC's RX/TX activity and error indicators.

---
 rtl/activity_led_pkg.sv | 35 +++
 rtl/activity_led_rise_detect.sv | 29 ++
 rtl/activity_led.sv | 153 +++++++++++++++
 tb/tb_activity_led.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activity_led_pkg.sv
// ---------------------------------------------------------------------------
// activity_led_pkg
//
// Shared definitions for the activity LED and related indicator blocks.
//   - State encoding constants and the FSM state type used by activity_led.
//   - counterWidth(): bits needed to hold values 0..maxValue, used to size
//     phase and queue counters in LED/indicator blocks.
//   - maxOf(): larger of two integers, for sizing a counter shared by two
//     phases of different length.
// ---------------------------------------------------------------------------
package activity_led_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_ON   = 2'd1;
    localparam logic [1:0] STATE_OFF  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_ON   = STATE_ON,
        ST_OFF  = STATE_OFF
    } state_t;

    // A counter always gets at least one bit, even for degenerate sizes.
    function automatic int counterWidth(input int maxValue);
        if (maxValue < 1) begin
            return 1;
        end
        return $clog2(maxValue + 1);
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/activity_led_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
//
// One-cycle rising-edge detector for a synchronous level signal.
//   i_clk   : clock
//   i_sig   : level input (already synchronous to i_clk)
//   o_rise  : high for the single cycle in which i_sig is high and was low
//             on the previous cycle
//
// The history register deliberately has no reset: it keeps tracking the
// input while the surrounding block is held in reset, so a level that is
// already high when reset is released is not mistaken for a new edge.
// ---------------------------------------------------------------------------
module rise_detect (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sigQ;

    // Previous-cycle copy of the input, updated unconditionally.
    always_ff @(posedge i_clk) begin
        r_sigQ <= i_sig;
    end

    assign o_rise = i_sig & ~r_sigQ;

endmodule

// File: rtl/activity_led.sv
// ---------------------------------------------------------------------------
// activity_led
//
// Stretches short activity strobes into blinks that are visible on a board
// LED. Every rising edge of i_event yields one blink: exactly ON_CYCLES
// cycles on, then at least OFF_CYCLES cycles off. Edges arriving while a
// blink is in progress are queued in a saturating counter and replayed
// back to back.
//
// Parameters:
//   ON_CYCLES   : LED-on duration in clock cycles (>= 1)
//   OFF_CYCLES  : minimum LED-off gap between blinks (>= 1)
//   MAX_PENDING : saturation value of the queued-blink counter (>= 1)
//   INVERT      : 1 makes o_led active-low
//
// Ports:
//   i_clk     : single clock for all logic
//   i_rst     : synchronous active-high reset
//   i_event   : activity strobe; a long level counts as one event
//   o_led     : registered LED pin drive, active level is ~INVERT
//   o_busy    : high while a blink (on phase or off gap) is in progress
//   o_pending : number of queued blinks
// ---------------------------------------------------------------------------
module activity_led
    import activity_led_pkg::*;
#(
    parameter int ON_CYCLES   = 2500000,
    parameter int OFF_CYCLES  = 2500000,
    parameter int MAX_PENDING = 3,
    parameter bit INVERT      = 1'b0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_event,
    output logic                                  o_led,
    output logic                                  o_busy,
    output logic [counterWidth(MAX_PENDING)-1:0]  o_pending
);

    localparam int PHASE_W = counterWidth(maxOf(ON_CYCLES, OFF_CYCLES));
    localparam int PEND_W  = counterWidth(MAX_PENDING);

    // The phase counter is loaded with length-1 and the phase ends on the
    // cycle it reads zero, so each phase lasts exactly its length.
    localparam logic [PHASE_W-1:0] ON_LOAD  = PHASE_W'(ON_CYCLES - 1);
    localparam logic [PHASE_W-1:0] OFF_LOAD = PHASE_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

    state_t              r_state;
    state_t              w_stateNext;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  w_phaseNext;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_pendingNext;
    logic                r_led;
    logic                w_rise;
    logic                w_pendInc;
    logic                w_pendDec;

    rise_detect u_riseDetect (
        .i_clk  (i_clk),
        .i_sig  (i_event),
        .o_rise (w_rise)
    );

    // Next-state, phase-counter and queue-request logic.
    // An edge seen on the last OFF cycle when nothing is queued is consumed
    // directly by starting the next blink, so it never touches the queue.
    // When something is queued, the queued blink starts and a simultaneous
    // edge takes its place, leaving the queue depth unchanged.
    always_comb begin
        w_stateNext = r_state;
        w_phaseNext = r_phase;
        w_pendInc   = 1'b0;
        w_pendDec   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_stateNext = ST_ON;
                    w_phaseNext = ON_LOAD;
                end
            end

            ST_ON: begin
                w_pendInc = w_rise;
                if (r_phase == '0) begin
                    w_stateNext = ST_OFF;
                    w_phaseNext = OFF_LOAD;
                end else begin
                    w_phaseNext = r_phase - PHASE_W'(1);
                end
            end

            ST_OFF: begin
                if (r_phase == '0) begin
                    if (r_pending != '0) begin
                        w_stateNext = ST_ON;
                        w_phaseNext = ON_LOAD;
                        w_pendDec   = 1'b1;
                        w_pendInc   = w_rise;
                    end else if (w_rise) begin
                        w_stateNext = ST_ON;
                        w_phaseNext = ON_LOAD;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end else begin
                    w_pendInc   = w_rise;
                    w_phaseNext = r_phase - PHASE_W'(1);
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Saturating queue update; an increment and a decrement in the same
    // cycle cancel, which also covers the case of a full queue.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_pendInc && !w_pendDec) begin
            if (r_pending != PEND_MAX) begin
                w_pendingNext = r_pending + PEND_W'(1);
            end
        end else if (w_pendDec && !w_pendInc) begin
            w_pendingNext = r_pending - PEND_W'(1);
        end
    end

    // State, counters and the LED pin register. The LED is registered from
    // the next state so it lines up exactly with the ON state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_pending <= '0;
            r_led     <= INVERT;
        end else begin
            r_state   <= w_stateNext;
            r_phase   <= w_phaseNext;
            r_pending <= w_pendingNext;
            r_led     <= (w_stateNext == ST_ON) ^ INVERT;
        end
    end

    assign o_led     = r_led;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_pending = r_pending;

endmodule

// File: tb/tb_activity_led.sv
// ---------------------------------------------------------------------------
// tb_activity_led
//
// Directed bench for activity_led with ON_CYCLES=4, OFF_CYCLES=3,
// MAX_PENDING=2. Two instances share stimulus: one active-high, one with
// INVERT=1. Cycle k is the clock period after posedge k; each cycle the
// bench samples outputs on the falling edge, then drives that cycle's
// inputs.
// ---------------------------------------------------------------------------
module tb_activity_led;

    logic       clk;
    logic       rst;
    logic       evt;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       ledInv;
    logic       busyInv;
    logic [1:0] pendingInv;

    int nVectors;
    int nMiscompares;

    activity_led #(
        .ON_CYCLES   (4),
        .OFF_CYCLES  (3),
        .MAX_PENDING (2),
        .INVERT      (1'b0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_event   (evt),
        .o_led     (led),
        .o_busy    (busy),
        .o_pending (pending)
    );

    activity_led #(
        .ON_CYCLES   (4),
        .OFF_CYCLES  (3),
        .MAX_PENDING (2),
        .INVERT      (1'b1)
    ) dutInv (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_event   (evt),
        .o_led     (ledInv),
        .o_busy    (busyInv),
        .o_pending (pendingInv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Holds reset for three cycles with the given event level and returns at
    // the falling edge of cycle 0 with reset already released.
    task automatic doReset(input logic evtLevel);
        @(negedge clk);
        rst = 1'b1;
        evt = evtLevel;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        doReset(1'b1);
        for (int c = 0; c <= 8; c++) begin
            nVectors++;
            if (led !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_led cycle %0d: got %b expected 0", c, led);
            end
            nVectors++;
            if (busy !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", c, busy);
            end
            nVectors++;
            if (pending !== 2'd0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_pending cycle %0d: got %0d expected 0", c, pending);
            end
            nVectors++;
            if (ledInv !== 1'b1) begin
                nMiscompares++;
                $display("[TB] FAIL reset_led_inv cycle %0d: got %b expected 1", c, ledInv);
            end
            evt = (c < 5);
            @(negedge clk);
        end
    endtask

    task automatic test_single_event();
        logic expLed;
        logic expBusy;
        $display("[TB] test_single_event");
        doReset(1'b0);
        for (int c = 0; c <= 24; c++) begin
            expLed  = (c >= 11 && c <= 14);
            expBusy = (c >= 11 && c <= 17);
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL single_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL single_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            nVectors++;
            if (pending !== 2'd0) begin
                nMiscompares++;
                $display("[TB] FAIL single_pending cycle %0d: got %0d expected 0", c, pending);
            end
            evt = (c == 10);
            @(negedge clk);
        end
    endtask

    task automatic test_held_level();
        logic expLed;
        logic expBusy;
        $display("[TB] test_held_level");
        doReset(1'b0);
        for (int c = 0; c <= 70; c++) begin
            expLed  = (c >= 11 && c <= 14);
            expBusy = (c >= 11 && c <= 17);
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL held_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL held_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            evt = (c >= 10 && c <= 59);
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic       expLed;
        logic       expBusy;
        logic [1:0] expPend;
        $display("[TB] test_saturation");
        doReset(1'b0);
        for (int c = 0; c <= 36; c++) begin
            expLed  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
            expBusy = (c >= 11 && c <= 31);
            if (c >= 13 && c <= 14)      expPend = 2'd1;
            else if (c >= 15 && c <= 17) expPend = 2'd2;
            else if (c >= 18 && c <= 24) expPend = 2'd1;
            else                         expPend = 2'd0;
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL sat_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL sat_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            nVectors++;
            if (pending !== expPend) begin
                nMiscompares++;
                $display("[TB] FAIL sat_pending cycle %0d: got %0d expected %0d", c, pending, expPend);
            end
            evt = (c == 10) || (c == 12) || (c == 14) || (c == 16);
            @(negedge clk);
        end
    endtask

    task automatic test_last_off_edge();
        logic       expLed;
        logic       expBusy;
        logic [1:0] expPend;
        $display("[TB] test_last_off_edge");
        // Edge on the last OFF cycle with an empty queue.
        doReset(1'b0);
        for (int c = 0; c <= 30; c++) begin
            expLed  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21);
            expBusy = (c >= 11 && c <= 24);
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff0_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff0_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            nVectors++;
            if (pending !== 2'd0) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff0_pending cycle %0d: got %0d expected 0", c, pending);
            end
            evt = (c == 10) || (c == 17);
            @(negedge clk);
        end
        // Same edge with one blink already queued.
        doReset(1'b0);
        for (int c = 0; c <= 36; c++) begin
            expLed  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
            expBusy = (c >= 11 && c <= 31);
            expPend = (c >= 13 && c <= 24) ? 2'd1 : 2'd0;
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff1_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff1_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            nVectors++;
            if (pending !== expPend) begin
                nMiscompares++;
                $display("[TB] FAIL lastoff1_pending cycle %0d: got %0d expected %0d", c, pending, expPend);
            end
            evt = (c == 10) || (c == 12) || (c == 17);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic expLed;
        logic expBusy;
        $display("[TB] test_reset_mid_blink");
        doReset(1'b0);
        for (int c = 0; c <= 56; c++) begin
            expLed  = (c >= 11 && c <= 12) || (c >= 46 && c <= 49);
            expBusy = (c >= 11 && c <= 12) || (c >= 46 && c <= 52);
            nVectors++;
            if (led !== expLed) begin
                nMiscompares++;
                $display("[TB] FAIL midrst_led cycle %0d: got %b expected %b", c, led, expLed);
            end
            nVectors++;
            if (busy !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL midrst_busy cycle %0d: got %b expected %b", c, busy, expBusy);
            end
            nVectors++;
            if (pending !== 2'd0) begin
                nMiscompares++;
                $display("[TB] FAIL midrst_pending cycle %0d: got %0d expected 0", c, pending);
            end
            rst = (c == 12);
            evt = (c == 10) || (c >= 12 && c <= 40) || (c == 45);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_invert();
        logic expLedInv;
        logic expBusy;
        $display("[TB] test_invert");
        doReset(1'b0);
        for (int c = 0; c <= 24; c++) begin
            expLedInv = !(c >= 11 && c <= 14);
            expBusy   = (c >= 11 && c <= 17);
            nVectors++;
            if (ledInv !== expLedInv) begin
                nMiscompares++;
                $display("[TB] FAIL invert_led cycle %0d: got %b expected %b", c, ledInv, expLedInv);
            end
            nVectors++;
            if (busyInv !== expBusy) begin
                nMiscompares++;
                $display("[TB] FAIL invert_busy cycle %0d: got %b expected %b", c, busyInv, expBusy);
            end
            nVectors++;
            if (pendingInv !== 2'd0) begin
                nMiscompares++;
                $display("[TB] FAIL invert_pending cycle %0d: got %0d expected 0", c, pendingInv);
            end
            evt = (c == 10);
            @(negedge clk);
        end
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst          = 1'b1;
        evt          = 1'b0;
        test_reset();
        test_single_event();
        test_held_level();
        test_saturation();
        test_last_off_edge();
        test_reset_mid_blink();
        test_invert();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
